// File: rtl/tnoc_axi_write_outstanding_controller.sv
// tnoc_axi_write_outstanding_controller
//
// Handshake-level controller for the AXI write path of the NoC master adapter.
// Only AW/W/B valid/ready pass through here; payload buses bypass this block.
//   - Caps writes in flight (AW accepted, B not yet returned) at MAX_OUTSTANDING.
//   - Optionally holds W beats until their AW has been accepted (ALLOW_EARLY_W=0).
//   - Watchdog on missing B responses, and a flag for B responses that arrive
//     while nothing is outstanding.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   i_aw_valid / o_aw_ready   AW handshake with the request side
//   o_aw_valid / i_aw_ready   AW handshake with the AXI slave
//   i_w_valid, i_w_last / o_w_ready   W handshake with the request side
//   o_w_valid / i_w_ready     W handshake with the AXI slave
//   i_b_valid / o_b_ready     B handshake with the AXI slave
//   o_b_valid / i_b_ready     B handshake with the response side
//   i_error_clear             clears both sticky error flags
//   o_outstanding             writes currently in flight
//   o_timeout                 sticky: B watchdog expired
//   o_unexpected_b            sticky: B handshake seen with nothing outstanding
module tnoc_axi_write_outstanding_controller #(
    parameter int MAX_OUTSTANDING = 8,
    parameter bit ALLOW_EARLY_W   = 1'b0,
    parameter int TIMEOUT_CYCLES  = 1024,
    localparam int CW = $clog2(MAX_OUTSTANDING + 1),
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_aw_valid,
    output logic          o_aw_ready,
    output logic          o_aw_valid,
    input  logic          i_aw_ready,
    input  logic          i_w_valid,
    input  logic          i_w_last,
    output logic          o_w_ready,
    output logic          o_w_valid,
    input  logic          i_w_ready,
    input  logic          i_b_valid,
    output logic          o_b_ready,
    output logic          o_b_valid,
    input  logic          i_b_ready,
    input  logic          i_error_clear,
    output logic [CW-1:0] o_outstanding,
    output logic          o_timeout,
    output logic          o_unexpected_b
);

    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);
    localparam logic [TW-1:0] TMR_MAX = TW'(TIMEOUT_CYCLES);

    logic [CW-1:0] outstanding, outstanding_nxt;
    logic [CW-1:0] w_credit, w_credit_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic          full;
    logic          w_open;
    logic          aw_fire, w_last_fire, b_fire;
    logic          unexpected_set, timeout_set;

    // full only moves on aw_fire/b_fire, so a presented o_aw_valid is stable
    // until it is accepted.
    assign full       = (outstanding == MAX_CNT);
    assign o_aw_valid = i_aw_valid & ~full;
    assign o_aw_ready = i_aw_ready & ~full;

    // Credit is registered, so the first W beat of a burst appears no earlier
    // than the cycle after its AW handshake.
    assign w_open    = ALLOW_EARLY_W ? 1'b1 : (w_credit != '0);
    assign o_w_valid = i_w_valid & w_open;
    assign o_w_ready = i_w_ready & w_open;

    assign o_b_valid = i_b_valid;
    assign o_b_ready = i_b_ready;

    assign aw_fire     = o_aw_valid & i_aw_ready;
    assign w_last_fire = o_w_valid & i_w_ready & i_w_last;
    assign b_fire      = i_b_valid & i_b_ready;

    always_comb begin
        outstanding_nxt = outstanding;
        unexpected_set  = 1'b0;
        if (aw_fire && !b_fire) begin
            outstanding_nxt = outstanding + CW'(1);
        end else if (b_fire && !aw_fire) begin
            if (outstanding != '0) begin
                outstanding_nxt = outstanding - CW'(1);
            end else begin
                unexpected_set = 1'b1;
            end
        end
    end

    always_comb begin
        w_credit_nxt = w_credit;
        if (ALLOW_EARLY_W) begin
            w_credit_nxt = '0;
        end else if (aw_fire && !w_last_fire) begin
            if (w_credit != MAX_CNT) begin
                w_credit_nxt = w_credit + CW'(1);
            end
        end else if (w_last_fire && !aw_fire) begin
            if (w_credit != '0) begin
                w_credit_nxt = w_credit - CW'(1);
            end
        end
    end

    // Timeout fires on the transition into saturation only, so a clear while
    // the timer sits saturated does take effect.
    always_comb begin
        timer_nxt   = timer;
        timeout_set = 1'b0;
        if (TIMEOUT_CYCLES == 0) begin
            timer_nxt = '0;
        end else begin
            if (outstanding == '0 || b_fire) begin
                timer_nxt = '0;
            end else if (timer != TMR_MAX) begin
                timer_nxt = timer + TW'(1);
            end
            timeout_set = (timer != TMR_MAX) && (timer_nxt == TMR_MAX);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding    <= '0;
            w_credit       <= '0;
            timer          <= '0;
            o_timeout      <= 1'b0;
            o_unexpected_b <= 1'b0;
        end else begin
            outstanding    <= outstanding_nxt;
            w_credit       <= w_credit_nxt;
            timer          <= timer_nxt;
            o_timeout      <= timeout_set | (o_timeout & ~i_error_clear);
            o_unexpected_b <= unexpected_set | (o_unexpected_b & ~i_error_clear);
        end
    end

    assign o_outstanding = outstanding;

endmodule

// File: tb/tb_tnoc_axi_write_outstanding_controller.sv
// Bench for tnoc_axi_write_outstanding_controller. Two instances share one
// stimulus: inst 0 (MAX=4, W gated, 16-cycle watchdog) and inst 1 (MAX=2,
// early W, watchdog disabled). An integer reference model tracks both.
module tb_tnoc_axi_write_outstanding_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic i_aw_valid = 0, i_aw_ready = 0, i_w_valid = 0, i_w_last = 0, i_w_ready = 0;
    logic i_b_valid = 0, i_b_ready = 0, i_error_clear = 0;

    logic aw_valid0, aw_ready0, w_valid0, w_ready0, b_valid0, b_ready0, to0, ub0;
    logic aw_valid1, aw_ready1, w_valid1, w_ready1, b_valid1, b_ready1, to1, ub1;
    logic [2:0] out0;
    logic [1:0] out1;

    int n_chk  = 0;
    int n_pass = 0;

    int m_out[2];
    int m_cred[2];
    int m_tmr[2];
    bit m_to[2];
    bit m_ub[2];

    always #5 clk = ~clk;

    tnoc_axi_write_outstanding_controller #(
        .MAX_OUTSTANDING(4), .ALLOW_EARLY_W(1'b0), .TIMEOUT_CYCLES(16)
    ) dut0 (
        .clk(clk), .rst(rst),
        .i_aw_valid(i_aw_valid), .o_aw_ready(aw_ready0), .o_aw_valid(aw_valid0), .i_aw_ready(i_aw_ready),
        .i_w_valid(i_w_valid), .i_w_last(i_w_last), .o_w_ready(w_ready0), .o_w_valid(w_valid0),
        .i_w_ready(i_w_ready),
        .i_b_valid(i_b_valid), .o_b_ready(b_ready0), .o_b_valid(b_valid0), .i_b_ready(i_b_ready),
        .i_error_clear(i_error_clear), .o_outstanding(out0), .o_timeout(to0), .o_unexpected_b(ub0)
    );

    tnoc_axi_write_outstanding_controller #(
        .MAX_OUTSTANDING(2), .ALLOW_EARLY_W(1'b1), .TIMEOUT_CYCLES(0)
    ) dut1 (
        .clk(clk), .rst(rst),
        .i_aw_valid(i_aw_valid), .o_aw_ready(aw_ready1), .o_aw_valid(aw_valid1), .i_aw_ready(i_aw_ready),
        .i_w_valid(i_w_valid), .i_w_last(i_w_last), .o_w_ready(w_ready1), .o_w_valid(w_valid1),
        .i_w_ready(i_w_ready),
        .i_b_valid(i_b_valid), .o_b_ready(b_ready1), .o_b_valid(b_valid1), .i_b_ready(i_b_ready),
        .i_error_clear(i_error_clear), .o_outstanding(out1), .o_timeout(to1), .o_unexpected_b(ub1)
    );

    function automatic int pmax(input int k);
        return (k == 0) ? 4 : 2;
    endfunction
    function automatic bit pew(input int k);
        return (k == 0) ? 1'b0 : 1'b1;
    endfunction
    function automatic int pto(input int k);
        return (k == 0) ? 16 : 0;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // Reference model: counts writes in flight, W credit and watchdog age.
    task automatic model_step(input int k);
        bit full, gate, awf, wlf, bf, set_ub, set_to;
        int o, c, t;
        full = (m_out[k] == pmax(k));
        gate = pew(k) || (m_cred[k] != 0);
        awf  = i_aw_valid && i_aw_ready && !full;
        wlf  = i_w_valid && i_w_ready && i_w_last && gate;
        bf   = i_b_valid && i_b_ready;
        o = m_out[k];
        set_ub = 1'b0;
        if (awf && !bf) o = o + 1;
        else if (bf && !awf) begin
            if (o > 0) o = o - 1;
            else set_ub = 1'b1;
        end
        c = 0;
        if (!pew(k)) begin
            c = m_cred[k] + int'(awf) - int'(wlf);
            if (c < 0) c = 0;
            if (c > pmax(k)) c = pmax(k);
        end
        if (pto(k) == 0 || m_out[k] == 0 || bf) t = 0;
        else t = (m_tmr[k] + 1 > pto(k)) ? pto(k) : m_tmr[k] + 1;
        set_to = (pto(k) > 0) && (m_tmr[k] != pto(k)) && (t == pto(k));
        m_out[k]  <= o;
        m_cred[k] <= c;
        m_tmr[k]  <= t;
        m_to[k]   <= set_to || (m_to[k] && !i_error_clear);
        m_ub[k]   <= set_ub || (m_ub[k] && !i_error_clear);
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                m_out[k]  <= 0;
                m_cred[k] <= 0;
                m_tmr[k]  <= 0;
                m_to[k]   <= 1'b0;
                m_ub[k]   <= 1'b0;
            end
        end else begin
            model_step(0);
            model_step(1);
        end
    end

    task automatic cmp(input int k, input logic av, input logic ar, input logic wv, input logic wr,
                       input logic bv, input logic br, input int oc, input logic t, input logic u);
        bit full, gate;
        full = (m_out[k] == pmax(k));
        gate = pew(k) || (m_cred[k] != 0);
        chk($sformatf("i%0d aw_valid", k), int'(av), int'(i_aw_valid && !full));
        chk($sformatf("i%0d aw_ready", k), int'(ar), int'(i_aw_ready && !full));
        chk($sformatf("i%0d w_valid", k), int'(wv), int'(i_w_valid && gate));
        chk($sformatf("i%0d w_ready", k), int'(wr), int'(i_w_ready && gate));
        chk($sformatf("i%0d b_valid", k), int'(bv), int'(i_b_valid));
        chk($sformatf("i%0d b_ready", k), int'(br), int'(i_b_ready));
        chk($sformatf("i%0d outstanding", k), oc, m_out[k]);
        chk($sformatf("i%0d timeout", k), int'(t), int'(m_to[k]));
        chk($sformatf("i%0d unexpected_b", k), int'(u), int'(m_ub[k]));
    endtask

    always @(negedge clk) begin
        cmp(0, aw_valid0, aw_ready0, w_valid0, w_ready0, b_valid0, b_ready0, int'(out0), to0, ub0);
        cmp(1, aw_valid1, aw_ready1, w_valid1, w_ready1, b_valid1, b_ready1, int'(out1), to1, ub1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i_aw_valid = 0; i_aw_ready = 0; i_w_valid = 0; i_w_last = 0; i_w_ready = 0;
        i_b_valid = 0; i_b_ready = 0; i_error_clear = 0;
    endtask

    task automatic do_reset();
        cyc();
        idle();
        rst = 1;
        cyc();
        cyc();
        rst = 0;
    endtask

    initial begin
        idle();
        cyc();
        cyc();
        rst = 0;

        // Unexpected B, then clear colliding with a new unexpected B.
        i_b_valid = 1; i_b_ready = 1;
        cyc();
        idle();
        @(negedge clk);
        chk("t5 ub set", int'(ub0), 1);
        chk("t5 out stays 0", int'(out0), 0);
        i_b_valid = 1; i_b_ready = 1; i_error_clear = 1;
        cyc();
        idle();
        @(negedge clk);
        chk("t5 set beats clear", int'(ub0), 1);
        i_error_clear = 1;
        cyc();
        idle();
        @(negedge clk);
        chk("t5 cleared", int'(ub0), 0);

        // W offered before AW: held on inst 0, passed on inst 1.
        do_reset();
        i_w_valid = 1; i_w_ready = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t2 w held", int'(w_valid0), 0);
            chk("t2 w early", int'(w_valid1), 1);
            cyc();
        end
        i_aw_valid = 1; i_aw_ready = 1;
        @(negedge clk);
        chk("t2 w held at aw_fire", int'(w_valid0), 0);
        cyc();
        i_aw_valid = 0; i_aw_ready = 0;
        @(negedge clk);
        chk("t2 w after aw", int'(w_valid0), 1);
        chk("t2 out", int'(out0), 1);
        cyc();
        cyc();
        cyc();
        i_w_last = 1;
        cyc();
        i_w_last = 0;
        @(negedge clk);
        chk("t2 credit back to 0", int'(w_valid0), 0);
        idle();

        // Cap on writes in flight (inst 1, MAX=2).
        do_reset();
        i_aw_valid = 1; i_aw_ready = 1;
        @(negedge clk);
        chk("t1 first ready", int'(aw_ready1), 1);
        cyc();
        cyc();
        @(negedge clk);
        chk("t1 out full", int'(out1), 2);
        chk("t1 third held ready", int'(aw_ready1), 0);
        chk("t1 third held valid", int'(aw_valid1), 0);
        cyc();
        i_b_valid = 1; i_b_ready = 1;
        @(negedge clk);
        chk("t1 still full at b", int'(aw_ready1), 0);
        cyc();
        i_b_valid = 0; i_b_ready = 0;
        @(negedge clk);
        chk("t1 released", int'(aw_ready1), 1);
        cyc();
        @(negedge clk);
        chk("t1 third accepted", int'(out1), 2);
        idle();

        // Same-cycle aw_fire with b_fire and with w_last_fire.
        do_reset();
        i_aw_valid = 1; i_aw_ready = 1;
        cyc();
        i_b_valid = 1; i_b_ready = 1; i_w_valid = 1; i_w_ready = 1; i_w_last = 1;
        cyc();
        idle();
        i_w_valid = 1;
        @(negedge clk);
        chk("t3 out stays 1", int'(out0), 1);
        chk("t3 credit stays 1", int'(w_valid0), 1);
        i_w_ready = 1; i_w_last = 1;
        cyc();
        i_w_ready = 0; i_w_last = 0;
        @(negedge clk);
        chk("t3 credit drained", int'(w_valid0), 0);
        idle();

        // Watchdog: exactly 16 cycles after aw_fire.
        do_reset();
        i_aw_valid = 1; i_aw_ready = 1;
        cyc();
        idle();
        for (int i = 1; i <= 16; i++) begin
            cyc();
            @(negedge clk);
            chk($sformatf("t4 timeout c%0d", i), int'(to0), (i >= 16) ? 1 : 0);
        end
        chk("t4 disabled watchdog", int'(to1), 0);
        i_aw_ready = 1;
        @(negedge clk);
        chk("t4 traffic continues", int'(aw_ready0), 1);
        i_aw_ready = 0;
        i_error_clear = 1;
        cyc();
        idle();
        @(negedge clk);
        chk("t4 cleared", int'(to0), 0);
        i_b_valid = 1; i_b_ready = 1;
        cyc();
        idle();
        i_aw_valid = 1; i_aw_ready = 1;
        cyc();
        idle();
        for (int i = 0; i < 14; i++) cyc();
        i_b_valid = 1; i_b_ready = 1;
        cyc();
        idle();
        for (int i = 0; i < 20; i++) cyc();
        @(negedge clk);
        chk("t4 no timeout with B", int'(to0), 0);

        // Asynchronous reset with state loaded.
        do_reset();
        i_aw_valid = 1; i_aw_ready = 1;
        cyc();
        cyc();
        cyc();
        idle();
        i_w_valid = 1; i_w_ready = 1; i_w_last = 1;
        cyc();
        idle();
        for (int i = 0; i < 9; i++) cyc();
        i_aw_ready = 1; i_w_valid = 1; i_w_ready = 1;
        #1;
        chk("t6 pre out", int'(out0), 3);
        chk("t6 pre full", int'(aw_ready1), 0);
        chk("t6 pre credit", int'(w_valid0), 1);
        #1 rst = 1;
        #1;
        chk("t6 out reset", int'(out0), 0);
        chk("t6 full released", int'(aw_ready1), 1);
        chk("t6 credit reset", int'(w_valid0), 0);
        chk("t6 flags", int'(to0) + int'(ub0), 0);
        cyc();
        idle();
        rst = 0;

        // Randomized traffic, occasional reset and clear.
        for (int i = 0; i < 4000; i++) begin
            cyc();
            rst           = ($urandom_range(0, 499) == 0);
            i_aw_valid    = ($urandom_range(0, 99) < 50);
            i_aw_ready    = ($urandom_range(0, 99) < 70);
            i_w_valid     = ($urandom_range(0, 99) < 60);
            i_w_ready     = ($urandom_range(0, 99) < 70);
            i_w_last      = ($urandom_range(0, 99) < 30);
            i_b_valid     = ($urandom_range(0, 99) < 15);
            i_b_ready     = ($urandom_range(0, 99) < 70);
            i_error_clear = ($urandom_range(0, 99) < 2);
        end
        cyc();
        rst = 0;
        idle();
        cyc();
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
